// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with 2-entry skid buffer, registered in_ready, flush and bubble insertion.
// Optional PIPE_STATS_EN adds saturating stall/bubble counters.
module pipe_stage_skid #(
  parameter int                CTRL_W      = 24,
  parameter int                DATA_W      = 170,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_ctrl  = out_valid ? main_ctrl : BUBBLE_CTRL;
  assign out_data  = main_data;
  assign occupancy = state;

  always_comb begin
    next_state = state;
    case (state)
      EMPTY:   if (in_fire) next_state = ONE;
      ONE: begin
        if (in_fire && !out_fire)      next_state = FULL;
        else if (!in_fire && out_fire) next_state = EMPTY;
      end
      FULL:    if (out_fire) next_state = ONE;
      default: next_state = EMPTY;
    endcase
    if (flush) next_state = EMPTY;
  end

  // Flush leaves the data registers untouched; only the state is squashed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != FULL);
      if (!flush) begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              main_ctrl <= in_ctrl;
              main_data <= in_data;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_ctrl <= in_ctrl;
              main_data <= in_data;
            end else if (in_fire) begin
              skid_ctrl <= in_ctrl;
              skid_data <= in_data;
            end
          end
          FULL: begin
            if (out_fire) begin
              main_ctrl <= skid_ctrl;
              main_data <= skid_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PIPE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (!out_valid && (bubble_cnt != '1))             bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid with a FIFO scoreboard of accepted entries.
module tb_pipe_stage_skid;

  localparam int                CTRL_W = 24;
  localparam int                DATA_W = 170;
  localparam int                CNT_W  = 2;
  localparam logic [CTRL_W-1:0] BUB    = 24'h5A0000;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;
`endif

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pipe_stage_skid #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .BUBBLE_CTRL(BUB), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_STATS_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge with inputs settled: score this cycle's transfers, then advance one clock.
  task automatic cycle();
    ent_t e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_out observed %0h expected none", out_data);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_ctrl", out_ctrl, e.ctrl);
          chk("out_data", out_data, e.data);
        end
      end
      if (in_valid && in_ready && !flush) begin
        e.ctrl = in_ctrl;
        e.data = in_data;
        sb.push_back(e);
      end
      if (flush) sb.delete();
    end else begin
      sb.delete();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put(input int v);
    in_valid = 1'b1;
    in_data  = DATA_W'(v);
    in_ctrl  = CTRL_W'(24'h000100 + v);
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((out_valid || sb.size() != 0) && n < 20) begin
      cycle();
      n++;
    end
    chk("drain_queue", sb.size(), 0);
    chk("drain_occ", occupancy, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, BUB);
    chk("rst_out_data", out_data, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_in_ready", in_ready, 0);
    cycle();

    // 1: first transfer after reset
    rst = 1'b0;
    in_valid = 1'b1; in_ctrl = 24'h00A5A5; in_data = DATA_W'(16'h1234); out_ready = 1'b1;
    chk("t1_in_ready_low", in_ready, 0);
    cycle();
    chk("t1_in_ready_high", in_ready, 1);
    chk("t1_out_valid_low", out_valid, 0);
    cycle();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_ctrl", out_ctrl, 24'h00A5A5);
    chk("t1_out_data", out_data, 16'h1234);
    chk("t1_occ", occupancy, 1);
    drain();

    // 2: streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      put(i);
      cycle();
      chk("t2_in_ready", in_ready, 1);
      chk("t2_out_valid", out_valid, 1);
      chk("t2_occ", occupancy, 1);
    end
    drain();

    // 3: backpressure fills the skid register
    out_ready = 1'b0;
    put(1); cycle();
    put(2); cycle();
    chk("t3_in_ready", in_ready, 0);
    chk("t3_occ_full", occupancy, 2);
    put(3); cycle();
    chk("t3_occ_hold", occupancy, 2);
    chk("t3_out_ctrl_held", out_ctrl, 24'h000101);
    out_ready = 1'b1;
    cycle();
    chk("t3_in_ready_back", in_ready, 1);
    cycle();
    drain();

    // 4: flush while full with a pending input
    out_ready = 1'b0;
    put(5); cycle();
    put(6); cycle();
    chk("t4_occ_full", occupancy, 2);
    put(7); flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_out_valid", out_valid, 0);
    chk("t4_out_ctrl", out_ctrl, BUB);
    chk("t4_occ", occupancy, 0);
    chk("t4_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) cycle();
    // Flush with a simultaneous delivery and acceptance
    put(9); cycle();
    put(10); flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4b_out_valid", out_valid, 0);
    chk("t4b_occ", occupancy, 0);
    repeat (2) cycle();
    drain();

    // 5: reset over flush while full
    out_ready = 1'b0;
    put(5); cycle();
    put(6); cycle();
    chk("t5_occ_full", occupancy, 2);
    in_valid = 1'b0; rst = 1'b1; flush = 1'b1;
    cycle();
    chk("t5_occ", occupancy, 0);
    chk("t5_out_data", out_data, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_ctrl", out_ctrl, BUB);
    rst = 1'b0; flush = 1'b0;
    chk("t5_in_ready_still_low", in_ready, 0);
    cycle();
    chk("t5_in_ready_up", in_ready, 1);

`ifdef PIPE_STATS_EN
    // 6: statistics counters
    rst = 1'b1; cycle();
    rst = 1'b0; out_ready = 1'b0;
    put(33); cycle(); cycle();
    in_valid = 1'b0;
    chk("t6_stall0", stall_cnt, 0);
    repeat (3) cycle();
    chk("t6_stall3", stall_cnt, 3);
    repeat (2) cycle();
    chk("t6_stall_sat", stall_cnt, 3);
    chk("t6_bubble2", bubble_cnt, 2);
    out_ready = 1'b1;
    cycle();
    repeat (4) cycle();
    chk("t6_bubble_sat", bubble_cnt, 3);
    chk("t6_stall_kept", stall_cnt, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised, generic inter-stage pipeline register for the processor (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a control bundle and a data bundle using a valid/ready handshake, with a 2-entry skid buffer so in_ready is a registered signal. Supports a synchronous flush, which is used for branch/jump squash. Inserts a programmable bubble control word whenever the stage is empty, so downstream stages see a NOP (RegWrite=0, memory idle).

Parameters:
CTRL_W, 24, width of control bundle (ALUop, RegWrite, RegDest, ALUsrc, jump, branch, RegSrc, mem ctrl, ...)
DATA_W, 170, width of data bundle (read data 1/2/3, sign-extended imm, PC, rt, rd)
BUBBLE_CTRL, 0, value driven on out_ctrl while out_valid=0
CNT_W, 16, width of statistics counters (used only with PIPE_STATS_EN)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
flush  in  1  squash all held entries (synchronous)
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept (registered)
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream data bundle
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head
out_ctrl  out  CTRL_W  head control; BUBBLE_CTRL when !out_valid
out_data  out  DATA_W  head data
occupancy  out  2  entries held: 0, 1 or 2

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: a main register (head) and a skid register. State is EMPTY(0) / ONE(1) / FULL(2); occupancy equals the state count.
- out_valid = (state != EMPTY); out_data = main register.
- out_ctrl = main ctrl when out_valid, else BUBBLE_CTRL (combinational mux).
- in_ready is a register that holds (next_state != FULL). It never depends combinationally on out_ready.
- Transitions, evaluated when flush=0:
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE: in_fire & out_fire -> ONE, main<=in. in_fire & !out_fire -> FULL, skid<=in. !in_fire & out_fire -> EMPTY. Otherwise hold.
  - FULL: in_fire is impossible (in_ready=0). out_fire -> ONE, main<=skid. Otherwise hold.
- Latency: from in_fire into EMPTY to out_valid=1 is 1 cycle. Throughput is 1 entry/cycle with out_ready held high.
- Order is strict FIFO; no entry is duplicated or lost except by flush.
- Flush has priority over all transitions:
  - next state EMPTY; next in_ready=1.
  - an entry accepted in the flush cycle is discarded.
  - an out_fire in the flush cycle counts as delivered.
  - out_valid=0 from the next cycle.
- Reset (rst=1 at posedge) has priority over flush:
  - state EMPTY; main and skid registers cleared to 0; in_ready=0.
  - in_ready rises at the first posedge with rst=0.
  - during reset: out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, occupancy=0.
  - reset asserted mid-transfer drops all held entries; no partial update.
- When EMPTY, out_data holds its stale value. Consumers must qualify it with out_valid.
- Bubble insertion: a downstream stall with no upstream data leaves out_ctrl=BUBBLE_CTRL, so a stall never re-executes a control word.

Optional Feature:
PIPE_STATS_EN
- Defined: adds outputs stall_cnt[CNT_W] and bubble_cnt[CNT_W].
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - bubble_cnt increments each cycle with !out_valid (rst=0).
  - both saturate at all-ones and clear only on rst; flush does not clear them.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, then in_valid=1 with ctrl=0x00A5A5, data=0x1234 and out_ready=1 -> in_ready=1 at first post-reset cycle; out_valid=1, out_ctrl=0x00A5A5, out_data=0x1234 one cycle later; occupancy=1.
2. Stream 8 entries (data 1..8) with out_ready=1 every cycle -> out_data 1..8 on consecutive cycles; in_ready stays 1; occupancy never exceeds 1.
3. Hold out_ready=0 while sending data 1,2,3 -> entries 1,2 accepted and in_ready=0 after the 2nd; occupancy=2. Raise out_ready -> outputs 1,2,3 in order with no loss.
4. Occupancy=2 (data 5,6), pulse flush with in_valid=1, data=7 -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, occupancy=0, in_ready=1; 7 never appears at the output.
5. Assert rst while FULL and simultaneously flush -> next cycle occupancy=0, out_data=0, in_ready=0; in_ready=1 one cycle after rst falls.
6. PIPE_STATS_EN defined: 3 cycles out_valid & !out_ready, then 4 empty cycles -> stall_cnt=3, bubble_cnt includes those 4; with CNT_W=2 and 5 stall cycles, stall_cnt saturates at 3.
